// File: rtl/fetch_stage_if.sv
// Bus bundle between the fetch stage and its environment: instruction ROM
// port, redirect request from the pipeline and the IF/ID register toward decode.
//   master : used by fetch_stage (drives imem address and IF/ID outputs)
//   slave  : used by the environment (ROM, redirect logic, decode)
interface fetch_stage_if;
    logic [31:0] imem_addr_o;
    logic [31:0] imem_data_i;
    logic        redirect_valid_i;
    logic [31:0] redirect_pc_i;
    logic        id_ready_i;
    logic        if_valid_o;
    logic [31:0] if_instr_o;
    logic [31:0] if_pc_o;
    logic [31:0] if_pc_plus4_o;
    logic        if_misaligned_o;
    logic [31:0] fetch_cnt_o;

    modport master (
        output imem_addr_o,
        input  imem_data_i,
        input  redirect_valid_i,
        input  redirect_pc_i,
        input  id_ready_i,
        output if_valid_o,
        output if_instr_o,
        output if_pc_o,
        output if_pc_plus4_o,
        output if_misaligned_o,
        output fetch_cnt_o
    );

    modport slave (
        input  imem_addr_o,
        output imem_data_i,
        output redirect_valid_i,
        output redirect_pc_i,
        output id_ready_i,
        input  if_valid_o,
        input  if_instr_o,
        input  if_pc_o,
        input  if_pc_plus4_o,
        input  if_misaligned_o,
        input  fetch_cnt_o
    );
endinterface

// File: rtl/fetch_stage.sv
// Instruction-fetch stage: owns the PC, addresses the combinational
// instruction ROM and registers {instr, pc, misaligned} into the IF/ID
// register with a valid/ready handshake toward decode.
// Ports:
//   clk_i  : clock, rising edge
//   rst_i  : synchronous active-high reset
//   bus    : fetch_stage_if.master (imem port, redirect, IF/ID outputs, fetch count)
module fetch_stage #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
    input  logic          clk_i,
    input  logic          rst_i,
    fetch_stage_if.master bus
);

    localparam int unsigned XLEN = 32;

    localparam logic [0:0] ST_RUN  = 1'b0;
    localparam logic [0:0] ST_HALT = 1'b1;

    logic [0:0]      state_q;
    logic [0:0]      state_d;
    logic [XLEN-1:0] pc_q;
    logic            valid_q;
    logic [XLEN-1:0] instr_q;
    logic [XLEN-1:0] out_pc_q;
    logic [XLEN-1:0] out_pc_plus4_q;
    logic            misaligned_q;
    logic [XLEN-1:0] fetch_cnt_q;

    logic xfer_c;
    logic load_c;
    logic aligned_c;

    assign xfer_c    = valid_q & bus.id_ready_i;
    assign load_c    = (state_q == ST_RUN) & (~valid_q | bus.id_ready_i);
    assign aligned_c = (pc_q[1:0] == 2'b00);

    // Next-state: a misaligned load parks the stage until a redirect.
    always_comb begin
        state_d = state_q;
        if (bus.redirect_valid_i) begin
            state_d = ST_RUN;
        end else if (load_c && !aligned_c) begin
            state_d = ST_HALT;
        end
    end

    // FSM state register
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= ST_RUN;
        end else begin
            state_q <= state_d;
        end
    end

    // PC, IF/ID register and handshake counter
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            pc_q           <= RESET_PC;
            valid_q        <= 1'b0;
            instr_q        <= NOP_INSTR;
            out_pc_q       <= '0;
            out_pc_plus4_q <= XLEN'(4);
            misaligned_q   <= 1'b0;
            fetch_cnt_q    <= '0;
        end else begin
            // The entry leaving this cycle counts even if a redirect flushes behind it.
            if (xfer_c) begin
                fetch_cnt_q <= fetch_cnt_q + XLEN'(1);
            end

            if (bus.redirect_valid_i) begin
                pc_q         <= bus.redirect_pc_i;
                valid_q      <= 1'b0;
                instr_q      <= NOP_INSTR;
                misaligned_q <= 1'b0;
            end else if (load_c) begin
                valid_q        <= 1'b1;
                out_pc_q       <= pc_q;
                out_pc_plus4_q <= pc_q + XLEN'(4);
                if (aligned_c) begin
                    instr_q      <= bus.imem_data_i;
                    misaligned_q <= 1'b0;
                    pc_q         <= pc_q + XLEN'(4);
                end else begin
                    // Bad target: hand decode a NOP tagged misaligned, keep pc_q.
                    instr_q      <= NOP_INSTR;
                    misaligned_q <= 1'b1;
                end
            end else if (xfer_c) begin
                // Only reachable in HALT: drain the held entry.
                valid_q      <= 1'b0;
                instr_q      <= NOP_INSTR;
                misaligned_q <= 1'b0;
            end
        end
    end

    assign bus.imem_addr_o     = pc_q;
    assign bus.if_valid_o      = valid_q;
    assign bus.if_instr_o      = instr_q;
    assign bus.if_pc_o         = out_pc_q;
    assign bus.if_pc_plus4_o   = out_pc_plus4_q;
    assign bus.if_misaligned_o = misaligned_q;
    assign bus.fetch_cnt_o     = fetch_cnt_q;

endmodule

// File: tb/tb_fetch_stage.sv
// Bench for fetch_stage: directed vector table covering reset, stall,
// redirect, misaligned halt and PC wrap, then random traffic checked against
// a transaction-level model of the delivered instruction stream.
module tb_fetch_stage;

    localparam logic [31:0] NOP = 32'h0000_0013;

    logic clk;
    logic rst;
    int   checks;
    int   errors;

    fetch_stage_if bus ();

    fetch_stage #(
        .RESET_PC  (32'h0000_0000),
        .NOP_INSTR (NOP)
    ) dut (
        .clk_i (clk),
        .rst_i (rst),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] rom_word(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
    endfunction

    assign bus.imem_data_i = rom_word(bus.imem_addr_o);

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    typedef struct {
        logic        rst;
        logic        red;
        logic [31:0] rpc;
        logic        rdy;
        logic        ev;
        logic [31:0] epc;
        logic [31:0] einstr;
        logic        emis;
        logic [31:0] ecnt;
        logic [31:0] eaddr;
    } vec_t;

    vec_t tbl[$];

    task automatic add(input logic r, input logic rd, input logic [31:0] rpc, input logic rdy,
                       input logic ev, input logic [31:0] epc, input logic [31:0] ein,
                       input logic emis, input logic [31:0] ecnt, input logic [31:0] eaddr);
        vec_t v;
        v.rst = r; v.red = rd; v.rpc = rpc; v.rdy = rdy;
        v.ev = ev; v.epc = epc; v.einstr = ein; v.emis = emis; v.ecnt = ecnt; v.eaddr = eaddr;
        tbl.push_back(v);
    endtask

    // Random-phase model state
    logic [31:0] m_pc;
    logic        m_blocked;
    logic [31:0] m_cnt;
    int          n_xfer;
    logic        prev_stall;
    logic        prev_rst;
    logic [31:0] snap_pc;
    logic [31:0] snap_instr;
    logic        snap_mis;

    initial begin
        checks = 0;
        errors = 0;
        rst = 1'b1;
        bus.redirect_valid_i = 1'b0;
        bus.redirect_pc_i    = '0;
        bus.id_ready_i       = 1'b0;

        // rst red rpc rdy | valid pc instr mis cnt imem_addr (state after the edge)
        add(1, 0, 32'h0, 1,  0, 32'h0,  NOP,              0, 0, 32'h0);
        add(0, 0, 32'h0, 1,  1, 32'h0,  rom_word(32'h0),  0, 0, 32'h4);
        add(0, 0, 32'h0, 1,  1, 32'h4,  rom_word(32'h4),  0, 1, 32'h8);
        add(0, 0, 32'h0, 1,  1, 32'h8,  rom_word(32'h8),  0, 2, 32'hC);
        add(0, 0, 32'h0, 1,  1, 32'hC,  rom_word(32'hC),  0, 3, 32'h10);
        for (int i = 0; i < 3; i++)
            add(0, 0, 32'h0, 0, 1, 32'hC, rom_word(32'hC), 0, 3, 32'h10);
        add(0, 0, 32'h0, 1,  1, 32'h10, rom_word(32'h10), 0, 4, 32'h14);
        add(0, 1, 32'h40, 0, 0, 32'h10, NOP,              0, 4, 32'h40);
        add(0, 0, 32'h0, 0,  1, 32'h40, rom_word(32'h40), 0, 4, 32'h44);
        add(0, 0, 32'h0, 1,  1, 32'h44, rom_word(32'h44), 0, 5, 32'h48);
        add(0, 1, 32'h42, 1, 0, 32'h44, NOP,              0, 6, 32'h42);
        add(0, 0, 32'h0, 0,  1, 32'h42, NOP,              1, 6, 32'h42);
        for (int i = 0; i < 6; i++)
            add(0, 0, 32'h0, 1, 0, 32'h42, NOP, 0, 7, 32'h42);
        add(0, 1, 32'h80, 1, 0, 32'h42, NOP,              0, 7, 32'h80);
        add(0, 0, 32'h0, 1,  1, 32'h80, rom_word(32'h80), 0, 7, 32'h84);
        add(0, 1, 32'hFFFF_FFFC, 1, 0, 32'h80, NOP,       0, 8, 32'hFFFF_FFFC);
        add(0, 0, 32'h0, 0,  1, 32'hFFFF_FFFC, rom_word(32'hFFFF_FFFC), 0, 8, 32'h0);
        add(0, 0, 32'h0, 1,  1, 32'h0,  rom_word(32'h0),  0, 9, 32'h4);
        add(1, 1, 32'h100, 1, 0, 32'h0, NOP,              0, 0, 32'h0);
        add(0, 0, 32'h0, 1,  1, 32'h0,  rom_word(32'h0),  0, 0, 32'h4);

        for (int i = 0; i < tbl.size(); i++) begin
            rst                  = tbl[i].rst;
            bus.redirect_valid_i = tbl[i].red;
            bus.redirect_pc_i    = tbl[i].rpc;
            bus.id_ready_i       = tbl[i].rdy;
            @(posedge clk);
            #1;
            check($sformatf("v%0d_valid", i), 32'(bus.if_valid_o), 32'(tbl[i].ev));
            check($sformatf("v%0d_instr", i), bus.if_instr_o, tbl[i].einstr);
            check($sformatf("v%0d_cnt", i), bus.fetch_cnt_o, tbl[i].ecnt);
            check($sformatf("v%0d_imem_addr", i), bus.imem_addr_o, tbl[i].eaddr);
            if (tbl[i].ev || tbl[i].rst) begin
                check($sformatf("v%0d_pc", i), bus.if_pc_o, tbl[i].epc);
                check($sformatf("v%0d_pc_plus4", i), bus.if_pc_plus4_o, tbl[i].epc + 32'd4);
                check($sformatf("v%0d_misaligned", i), 32'(bus.if_misaligned_o), 32'(tbl[i].emis));
            end
        end

        // Random traffic: the model tracks which PC decode must receive next.
        m_pc = 32'h0; m_blocked = 1'b0; m_cnt = 32'h0; n_xfer = 0;
        prev_stall = 1'b0; prev_rst = 1'b0;
        snap_pc = '0; snap_instr = '0; snap_mis = 1'b0;
        for (int cyc = 0; cyc < 3000; cyc++) begin
            logic        r_rst;
            logic        r_red;
            logic        r_rdy;
            logic [31:0] r_pc;
            int          sel;
            r_rst = (cyc == 0) || ($urandom_range(0, 299) == 0);
            r_red = ($urandom_range(0, 9) == 0);
            r_rdy = ($urandom_range(0, 3) != 0);
            sel   = $urandom_range(0, 15);
            if (sel == 0)
                r_pc = 32'hFFFF_FFF0 + 32'($urandom_range(0, 3) * 4);
            else if (sel < 3)
                r_pc = ($urandom & 32'h0000_0FFC) | 32'($urandom_range(1, 3));
            else
                r_pc = $urandom & 32'h0000_0FFC;

            rst                  = r_rst;
            bus.redirect_valid_i = r_red;
            bus.redirect_pc_i    = r_pc;
            bus.id_ready_i       = r_rdy;
            @(negedge clk);

            if (prev_rst)
                check("rnd_reset_valid", 32'(bus.if_valid_o), 32'h0);
            if (prev_stall) begin
                check("rnd_stall_valid", 32'(bus.if_valid_o), 32'h1);
                check("rnd_stall_pc", bus.if_pc_o, snap_pc);
                check("rnd_stall_instr", bus.if_instr_o, snap_instr);
                check("rnd_stall_mis", 32'(bus.if_misaligned_o), 32'(snap_mis));
            end
            check("rnd_cnt", bus.fetch_cnt_o, m_cnt);

            if (r_rst) begin
                m_pc = 32'h0; m_blocked = 1'b0; m_cnt = 32'h0;
            end else begin
                if (bus.if_valid_o && r_rdy) begin
                    n_xfer++;
                    check("rnd_xfer_after_halt", 32'(m_blocked), 32'h0);
                    check("rnd_pc", bus.if_pc_o, m_pc);
                    check("rnd_pc_plus4", bus.if_pc_plus4_o, m_pc + 32'd4);
                    if (m_pc[1:0] == 2'b00) begin
                        check("rnd_instr", bus.if_instr_o, rom_word(m_pc));
                        check("rnd_mis", 32'(bus.if_misaligned_o), 32'h0);
                        m_pc = m_pc + 32'd4;
                    end else begin
                        check("rnd_instr_nop", bus.if_instr_o, NOP);
                        check("rnd_mis", 32'(bus.if_misaligned_o), 32'h1);
                        m_blocked = 1'b1;
                    end
                    m_cnt = m_cnt + 32'd1;
                end
                if (r_red) begin
                    m_pc = r_pc;
                    m_blocked = 1'b0;
                end
            end

            prev_rst   = r_rst;
            prev_stall = !r_rst && !r_red && bus.if_valid_o && !r_rdy;
            snap_pc    = bus.if_pc_o;
            snap_instr = bus.if_instr_o;
            snap_mis   = bus.if_misaligned_o;
            @(posedge clk);
            #1;
        end

        checks++;
        if (n_xfer < 300) begin
            errors++;
            $display("FAIL rnd_throughput actual=%0d required>=300", n_xfer);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/fetch_stage.md
Name: fetch_stage

Overview:
- Instruction-fetch stage that owns the program counter and drives the address of the combinational instruction ROM (instr_mem).
- Registers the returned word together with its PC into an IF/ID output register using a valid/ready handshake toward decode.
- Handles stalls, control-flow redirects (branch, jump, trap) and misaligned fetch targets.
- Sits between the pipeline's redirect logic and the decode stage.

Parameters:
- RESET_PC, 32'h0000_0000, PC value loaded on reset.
- NOP_INSTR, 32'h0000_0013, word presented on if_instr_o when no valid instruction is held (addi x0,x0,0).

Ports:
- clk_i  input  1  system clock, all state updates on rising edge
- rst_i  input  1  synchronous active-high reset
- imem_addr_o  output  32  byte address to instr_mem read_addr_i
- imem_data_i  input  32  instruction word from instr_mem read_data_o, combinational in imem_addr_o
- redirect_valid_i  input  1  pulse: take redirect_pc_i as next fetch PC, flush the output register
- redirect_pc_i  input  32  redirect target byte address
- id_ready_i  input  1  decode can accept the output register this cycle
- if_valid_o  output  1  output register holds an instruction
- if_instr_o  output  32  fetched instruction
- if_pc_o  output  32  PC of if_instr_o
- if_pc_plus4_o  output  32  if_pc_o + 4, modulo 2^32
- if_misaligned_o  output  1  held entry came from a PC with pc[1:0] != 0
- fetch_cnt_o  output  32  number of completed IF->ID handshakes, wraps

Behaviour:
- State: pc_q (32 bit), output register {valid, instr, pc, misaligned}, FSM {RUN, HALT}, fetch_cnt_q.
- imem_addr_o = pc_q, combinationally; no other path drives it.
- Reset (rst_i=1 at a clock edge, overrides every other input):
  - pc_q = RESET_PC; FSM = RUN.
  - if_valid_o = 0, if_instr_o = NOP_INSTR, if_pc_o = 0, if_pc_plus4_o = 4.
  - if_misaligned_o = 0, fetch_cnt_o = 0.
- Handshake: xfer = if_valid_o & id_ready_i. load = RUN & (!if_valid_o | id_ready_i).
- Priority per edge: rst_i > redirect_valid_i > load/hold.
- Redirect:
  - pc_q <= redirect_pc_i; if_valid_o <= 0; if_misaligned_o <= 0; if_instr_o <= NOP_INSTR; FSM <= RUN.
  - Applies in any state and wins over a simultaneous load or stall.
  - The instruction at the redirect target appears with if_valid_o = 1 on the following edge (redirect-to-valid latency: 2 edges).
  - fetch_cnt still increments if xfer is true in the same cycle.
- Load with pc_q[1:0] == 0:
  - Output register <= {1, imem_data_i, pc_q, 0}; pc_q <= pc_q + 4 (wraps 32'hFFFF_FFFC -> 0).
- Load with pc_q[1:0] != 0:
  - Output register <= {1, NOP_INSTR, pc_q, 1}; pc_q unchanged; FSM <= HALT.
- HALT:
  - No loads. The held entry stays until xfer, then if_valid_o <= 0.
  - Remains in HALT until redirect_valid_i or rst_i.
- Stall (if_valid_o & !id_ready_i & !redirect): output register and pc_q hold; imem_addr_o stable.
- After reset, the first valid instruction (from RESET_PC) appears on the first edge after rst_i deasserts. Steady state: 1 instruction per cycle when id_ready_i = 1.
- fetch_cnt_q increments by 1 on every xfer, including misaligned entries; wraps from 32'hFFFF_FFFF to 0.
- if_pc_plus4_o is derived from the registered if_pc_o, not from pc_q.

Test Plan:
- Reset release, RESET_PC=0, ROM[0..2]=A,B,C, id_ready_i=1 → edges 1,2,3 give (valid,pc,instr) = (1,0,A),(1,4,B),(1,8,C); fetch_cnt_o = 3 after edge 4.
- Stall: id_ready_i=0 for 3 cycles while holding pc=4 → if_instr_o=B, if_pc_o=4, imem_addr_o=8 all stable; on release, next edge gives pc=8.
- Redirect to 32'h40 together with id_ready_i=0 → next edge if_valid_o=0, imem_addr_o=32'h40; following edge pc=32'h40, instr=ROM[16].
- Redirect to 32'h42 → load gives valid=1, misaligned=1, instr=32'h13, pc=32'h42. FSM stays in HALT; after xfer valid=0 and stays 0 for 5 cycles. Redirect to 32'h80 resumes fetch at 32'h80.
- Wrap: redirect to 32'hFFFF_FFFC → entry pc=32'hFFFF_FFFC, if_pc_plus4_o=0, next entry pc=0.
- rst_i asserted mid-stream with valid=1 and redirect_valid_i=1 → next edge valid=0, pc_q=RESET_PC, fetch_cnt_o=0, FSM=RUN.
